// File: rtl/bib3_pkg.sv
// Shared definitions for the buyruk executor: opcodes, FSM states and
// buyruk field positions. A buyruk is {opcode, A, B}, with A and B each
// dw bits wide and the opcode OPC_W bits wide.
package bib3_pkg;

  localparam int unsigned OPC_W = 3;

  localparam logic [OPC_W-1:0] OP_ADD = 3'b000;
  localparam logic [OPC_W-1:0] OP_SUB = 3'b001;
  localparam logic [OPC_W-1:0] OP_AND = 3'b010;
  localparam logic [OPC_W-1:0] OP_OR  = 3'b011;
  localparam logic [OPC_W-1:0] OP_XOR = 3'b100;
  localparam logic [OPC_W-1:0] OP_MUL = 3'b101;
  localparam logic [OPC_W-1:0] OP_SHL = 3'b110;
  localparam logic [OPC_W-1:0] OP_CMP = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_e;

  // B occupies the lowest dw bits of the buyruk.
  localparam int unsigned B_LSB = 0;

  // A sits directly above B.
  function automatic int unsigned a_lsb(input int unsigned dw);
    return dw;
  endfunction

  // The opcode sits directly above A.
  function automatic int unsigned opc_lsb(input int unsigned dw);
    return 2 * dw;
  endfunction

endpackage

// File: rtl/bib3_carpici.sv
// Sequential shift-add multiplier. A start_i pulse loads the operands.
// One bit of b_i is consumed per cycle for DATA_W cycles. done_o pulses for
// one cycle once product_o holds the full result.
// Ports:
//   clk, rst  : clock and synchronous active-high reset
//   start_i   : load a_i/b_i and begin
//   a_i, b_i  : unsigned operands
//   done_o    : one-cycle pulse, product_o is valid
//   product_o : a_i * b_i
module bib3_carpici #(
  parameter int unsigned DATA_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [DATA_W-1:0]     a_i,
  input  logic [DATA_W-1:0]     b_i,
  output logic                  done_o,
  output logic [2*DATA_W-1:0]   product_o
);

  localparam int unsigned PW = 2 * DATA_W;
  localparam int unsigned CW = $clog2(DATA_W + 1);

  logic [PW-1:0]     mcand_q;
  logic [DATA_W-1:0] mplier_q;
  logic [PW-1:0]     acc_q;
  logic [CW-1:0]     cnt_q;
  logic              busy_q;
  logic              done_q;

  // Shift-add datapath: add the shifted multiplicand when the current B bit is set.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        mcand_q  <= PW'(a_i);
        mplier_q <= b_i;
        acc_q    <= '0;
        cnt_q    <= CW'(DATA_W);
        busy_q   <= 1'b1;
      end else if (busy_q) begin
        if (mplier_q[0]) begin
          acc_q <= acc_q + mcand_q;
        end
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done_o    = done_q;
  assign product_o = acc_q;

endmodule

// File: rtl/buyruk_yurutucu.sv
// Buyruk executor. It accepts one {opcode, A, B} word per valid/ready
// handshake and executes it. Multiply runs through the multi-cycle
// shift-add unit. The result is held registered until the sink accepts it.
// Optional feature: defining INSTR_COUNT_EN adds the instr_count port, a
// counter of completed instructions.
// Ports:
//   clk, rst    : clock and synchronous active-high reset
//   in_valid    : buyruk present
//   in_ready    : block can accept a buyruk (IDLE only)
//   buyruk      : {opcode, A, B}
//   out_valid   : sonuc/ovf valid
//   out_ready   : sink accepts the result
//   sonuc       : result
//   ovf         : result truncated or wrapped
//   instr_count : completed instructions (INSTR_COUNT_EN only)
module buyruk_yurutucu
  import bib3_pkg::*;
#(
  parameter int unsigned DATA_W = 3,
  parameter int unsigned RES_W  = 4
`ifdef INSTR_COUNT_EN
  ,
  parameter int unsigned CNT_W  = 16
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [OPC_W+2*DATA_W-1:0] buyruk,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [RES_W-1:0]          sonuc,
`ifdef INSTR_COUNT_EN
  output logic [CNT_W-1:0]          instr_count,
`endif
  output logic                      ovf
);

  localparam int unsigned PW = 2 * DATA_W;
  // Wide enough for the largest shift (A << (2^DATA_W - 1)), the sum and the product.
  localparam int unsigned LW = DATA_W + (1 << DATA_W) + RES_W;

  state_e             state_q;
  logic [OPC_W-1:0]   op_q;
  logic [DATA_W-1:0]  a_q;
  logic [DATA_W-1:0]  b_q;
  logic [RES_W-1:0]   sonuc_q;
  logic               ovf_q;
  logic               out_valid_q;
  logic               in_ready_q;

  logic [OPC_W-1:0]   opc_in;
  logic [DATA_W-1:0]  a_in;
  logic [DATA_W-1:0]  b_in;
  logic               accept_c;
  logic               mul_start_c;
  logic               mul_done;
  logic [PW-1:0]      mul_product;
  logic [RES_W-1:0]   alu_sonuc_d;
  logic               alu_ovf_d;

  assign opc_in      = buyruk[opc_lsb(DATA_W) +: OPC_W];
  assign a_in        = buyruk[a_lsb(DATA_W) +: DATA_W];
  assign b_in        = buyruk[B_LSB +: DATA_W];
  assign accept_c    = in_valid && in_ready_q;
  // The multiplier loads on the accept edge, so its iterations overlap the MUL state.
  assign mul_start_c = accept_c && (opc_in == OP_MUL);

  bib3_carpici #(
    .DATA_W (DATA_W)
  ) u_carpici (
    .clk       (clk),
    .rst       (rst),
    .start_i   (mul_start_c),
    .a_i       (a_in),
    .b_i       (b_in),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  // Single-cycle operations on the latched operands.
  always_comb begin
    logic [LW-1:0] a_w;
    logic [LW-1:0] b_w;
    logic [LW-1:0] t;
    logic [2:0]    cmp3;
    alu_sonuc_d = '0;
    alu_ovf_d   = 1'b0;
    a_w         = LW'(a_q);
    b_w         = LW'(b_q);
    t           = '0;
    cmp3        = '0;
    case (op_q)
      OP_ADD: begin
        t           = a_w + b_w;
        alu_sonuc_d = RES_W'(t);
        alu_ovf_d   = |(t >> RES_W);
      end
      OP_SUB: begin
        t           = a_w - b_w;
        alu_sonuc_d = RES_W'(t);
        alu_ovf_d   = (a_q < b_q);
      end
      OP_AND: alu_sonuc_d = RES_W'(a_w & b_w);
      OP_OR:  alu_sonuc_d = RES_W'(a_w | b_w);
      OP_XOR: alu_sonuc_d = RES_W'(a_w ^ b_w);
      OP_SHL: begin
        t           = a_w << b_q;
        alu_sonuc_d = RES_W'(t);
        alu_ovf_d   = |(t >> RES_W);
      end
      OP_CMP: begin
        cmp3        = {(a_q > b_q), (a_q == b_q), (a_q < b_q)};
        alu_sonuc_d = RES_W'(cmp3);
      end
      default: begin
        alu_sonuc_d = '0;
        alu_ovf_d   = 1'b0;
      end
    endcase
  end

`ifdef INSTR_COUNT_EN
  logic [CNT_W-1:0] cnt_q;
`endif

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sonuc_q     <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef INSTR_COUNT_EN
      cnt_q       <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            op_q       <= opc_in;
            a_q        <= a_in;
            b_q        <= b_in;
            in_ready_q <= 1'b0;
            state_q    <= (opc_in == OP_MUL) ? MUL : EXEC;
          end
        end
        EXEC: begin
          sonuc_q     <= alu_sonuc_d;
          ovf_q       <= alu_ovf_d;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        MUL: begin
          if (mul_done) begin
            sonuc_q     <= RES_W'(mul_product);
            ovf_q       <= |(mul_product >> RES_W);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          // in_ready rises only after the exit edge, so there is no same-cycle bypass.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
`ifdef INSTR_COUNT_EN
            cnt_q       <= cnt_q + CNT_W'(1);
`endif
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sonuc     = sonuc_q;
  assign ovf       = ovf_q;
`ifdef INSTR_COUNT_EN
  assign instr_count = cnt_q;
`endif

endmodule

// File: tb/tb_buyruk_yurutucu.sv
// Scoreboard bench for buyruk_yurutucu. The driver pushes hand-computed
// expected results when a buyruk is accepted. A separate monitor pops and
// compares each result as the sink handshake is about to occur.
module tb_buyruk_yurutucu;

  localparam int unsigned DATA_W = 3;
  localparam int unsigned RES_W  = 4;
  localparam int unsigned BW     = 3 + 2 * DATA_W;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b1;
  logic [BW-1:0]   buyruk = '0;
  logic            in_ready;
  logic            out_valid;
  logic [RES_W-1:0] sonuc;
  logic            ovf;
`ifdef INSTR_COUNT_EN
  logic [15:0]     instr_count;
`endif

  typedef struct {
    logic [3:0] s;
    logic       o;
    int         lat;
    int         acc;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   first_cyc = 0;
  bit   prev_valid = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  buyruk_yurutucu dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .buyruk      (buyruk),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sonuc       (sonuc),
`ifdef INSTR_COUNT_EN
    .instr_count (instr_count),
`endif
    .ovf         (ovf)
  );

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  // Present a buyruk until it is accepted; acc is the cycle count just after the accept edge.
  task automatic accept_only(input logic [BW-1:0] b, output int acc, output bit ok);
    @(negedge clk);
    in_valid = 1'b1;
    buyruk   = b;
    ok       = 1'b0;
    acc      = 0;
    for (int i = 0; i < 60; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acc      = cyc;
    in_valid = 1'b0;
  endtask

  task automatic issue(input logic [BW-1:0] b, input logic [3:0] s, input logic o,
                       input int lat, input string name);
    int acc;
    bit ok;
    accept_only(b, acc, ok);
    if (ok) sb.push_back('{s: s, o: o, lat: lat, acc: acc, name: name});
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_pending", sb.size(), 0);
  endtask

  // Monitor: a result is compared on the cycle its handshake is due.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) first_cyc = cyc;
      prev_valid = out_valid;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk({e.name, "_sonuc"}, int'(sonuc), int'(e.s));
          chk({e.name, "_ovf"}, int'(ovf), int'(e.o));
          chk({e.name, "_latency"}, first_cyc - e.acc + 1, e.lat);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    bit ok;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_sonuc", int'(sonuc), 0);
    chk("rst_ovf", int'(ovf), 0);
`ifdef INSTR_COUNT_EN
    chk("rst_instr_count", int'(instr_count), 0);
`endif
    rst = 1'b0;

    // ADD 3+5 with step-by-step handshake visibility
    accept_only(9'b000_011_101, acc, ok);
    if (ok) sb.push_back('{s: 4'd8, o: 1'b0, lat: 2, acc: acc, name: "add_3_5"});
    @(negedge clk);
    chk("exec_in_ready", int'(in_ready), 0);
    chk("exec_out_valid", int'(out_valid), 0);
    @(negedge clk);
    chk("done_in_ready", int'(in_ready), 0);
    chk("done_out_valid", int'(out_valid), 1);
    @(negedge clk);
    chk("idle_in_ready", int'(in_ready), 1);
    chk("idle_out_valid", int'(out_valid), 0);

    // Directed operations
    issue(9'b001_010_101, 4'b1101, 1'b1, 2, "sub_2_5");
    issue(9'b111_101_101, 4'b0010, 1'b0, 2, "cmp_5_5");
    issue(9'b101_111_111, 4'b0001, 1'b1, 5, "mul_7_7");
    issue(9'b101_011_010, 4'd6,    1'b0, 5, "mul_3_2");
    issue(9'b010_110_011, 4'd2,    1'b0, 2, "and_6_3");
    issue(9'b011_100_001, 4'd5,    1'b0, 2, "or_4_1");
    issue(9'b100_111_101, 4'd2,    1'b0, 2, "xor_7_5");
    issue(9'b110_011_010, 4'd12,   1'b0, 2, "shl_3_2");
    issue(9'b110_111_010, 4'd12,   1'b1, 2, "shl_7_2");
    issue(9'b110_001_111, 4'd0,    1'b1, 2, "shl_1_7");
    issue(9'b000_111_111, 4'd14,   1'b0, 2, "add_7_7");
    issue(9'b001_000_000, 4'd0,    1'b0, 2, "sub_0_0");
    issue(9'b101_000_000, 4'd0,    1'b0, 5, "mul_0_0");
    issue(9'b101_101_011, 4'd15,   1'b0, 5, "mul_5_3");
    issue(9'b111_010_110, 4'b0001, 1'b0, 2, "cmp_2_6");
    issue(9'b111_110_010, 4'b0100, 1'b0, 2, "cmp_6_2");
    issue(9'b000_000_000, 4'd0,    1'b0, 2, "add_0_0");
    drain();

    // Backpressure: result held while the sink stalls, new buyruk ignored
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    issue(9'b000_011_101, 4'd8, 1'b0, 2, "bp_add_3_5");
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("bp_out_valid_seen", int'(ok), 1);
    in_valid = 1'b1;
    buyruk   = 9'b100_111_001;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_sonuc", int'(sonuc), 8);
      chk("bp_ovf", int'(ovf), 0);
      chk("bp_in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();
    @(negedge clk);
    chk("bp_back_idle", int'(in_ready), 1);

    // Reset during the second MUL cycle aborts the operation
    accept_only(9'b101_111_111, acc, ok);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_in_ready", int'(in_ready), 1);
    repeat (6) @(negedge clk);
    chk("abort_no_result", int'(out_valid), 0);
    issue(9'b000_001_001, 4'd2, 1'b0, 2, "add_1_1_after_rst");
    drain();

`ifdef INSTR_COUNT_EN
    // Instruction counter: ten completed ops, then cleared by reset
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("cnt_cleared", int'(instr_count), 0);
    for (int i = 0; i < 10; i++) begin
      issue(9'b000_010_011, 4'd5, 1'b0, 2, "cnt_add_2_3");
    end
    drain();
    @(negedge clk);
    chk("cnt_ten", int'(instr_count), 10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("cnt_rst", int'(instr_count), 0);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
